// File: rtl/hazard_sched.sv
// ---------------------------------------------------------------------------
// hazard_sched
//   Pipeline hazard controller and multi-cycle execute scheduler for the
//   5-stage core. Produces the E-stage forwarding selects, load-use stalls
//   and branch flushes. It also sequences a variable-latency execute unit
//   (mul/div) through an IDLE/MC_WAIT FSM. The FSM has a timeout counter and
//   a sticky error flag.
//
// Parameters
//   RA_W        register index width
//   MC_TIMEOUT  max cycles spent in MC_WAIT before the op is aborted (>=2)
//
// Ports
//   clk                     clock, rising edge
//   reset                   synchronous active-high reset
//   rs1_D, rs2_D            decode-stage source indices
//   rs1_E, rs2_E, rd_E      execute-stage sources / destination
//   rd_M, rd_W              memory / writeback destinations
//   LoadE                   E-stage instruction is a load
//   RegWriteM, RegWriteW    M / W instruction writes its rd
//   PCSrcE                  taken branch/jump resolved in E
//   mc_start_E              E-stage instruction needs the multi-cycle unit
//   mc_done                 multi-cycle result valid (1-cycle pulse)
//   ForwardAE, ForwardBE    00 regfile, 10 from M, 01 from W
//   StallF, StallD, StallE  hold PC, IF/ID, ID/EX
//   FlushD, FlushE          clear IF/ID, ID/EX
//   mc_go                   1-cycle launch pulse to the multi-cycle unit
//   mc_busy                 FSM is in MC_WAIT
//   mc_err                  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module hazard_sched #(
  parameter int RA_W       = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs1_D,
  input  logic [RA_W-1:0] rs2_D,
  input  logic [RA_W-1:0] rs1_E,
  input  logic [RA_W-1:0] rs2_E,
  input  logic [RA_W-1:0] rd_E,
  input  logic [RA_W-1:0] rd_M,
  input  logic [RA_W-1:0] rd_W,
  input  logic            LoadE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            PCSrcE,
  input  logic            mc_start_E,
  input  logic            mc_done,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            mc_go,
  output logic            mc_busy,
  output logic            mc_err
);

  localparam int                CNT_W    = $clog2(MC_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_MC_WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_err_q, mc_err_d;

  logic lw_stall;
  logic timeout_hit;

  // Forwarding select for one E-stage source. M is the younger producer,
  // so it takes priority over W. Register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (RegWriteM && (rd_M != '0) && (rd_M == rs))
      return 2'b10;
    else if (RegWriteW && (rd_W != '0) && (rd_W == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall    = LoadE && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  // Last permitted MC_WAIT cycle. mc_done in this same cycle still wins.
  assign timeout_hit = (state_q == S_MC_WAIT) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_err_q <= mc_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_err_d = mc_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (mc_start_E) begin
          state_d = S_MC_WAIT;
          cnt_d   = '0;
        end
      end
      S_MC_WAIT: begin
        if (mc_done) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          mc_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. All of it is combinational from the inputs and the current state.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    mc_go     = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(rs1_E);
      ForwardBE = fwd_sel(rs2_E);
      unique case (state_q)
        S_IDLE: begin
          if (mc_start_E) begin
            // Launch: freeze the front end. Branch and load-use are ignored
            // because the op stays in E.
            mc_go  = 1'b1;
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
          end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
          end
        end
        S_MC_WAIT: begin
          if (!mc_done && !timeout_hit) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
          end else begin
            // Release cycle. On a timeout abort, ID/EX is also cleared so
            // the abandoned op leaves no result.
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE | ~mc_done;
          end
        end
        default: ;
      endcase
    end
  end

  assign mc_busy = (state_q == S_MC_WAIT);
  assign mc_err  = mc_err_q;

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

  localparam int RA_W = 5;
  localparam int T    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [RA_W-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic            LoadE, RegWriteM, RegWriteW, PCSrcE, mc_start_E, mc_done;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, StallE, FlushD, FlushE, mc_go, mc_busy, mc_err;

  int errors = 0;
  int checks = 0;

  // Reference model state: whether a multi-cycle op is outstanding, how many
  // wait cycles it has already used, and the sticky error flag.
  bit m_wait = 0;
  int m_used = 0;
  bit m_err  = 0;

  hazard_sched #(.RA_W(RA_W), .MC_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .mc_start_E(mc_start_E), .mc_done(mc_done),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .mc_go(mc_go), .mc_busy(mc_busy), .mc_err(mc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [RA_W-1:0] rs);
    if (RegWriteM && rd_M != 0 && rd_M == rs) return 2'b10;
    if (RegWriteW && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; mc_start_E = 0; mc_done = 0;
  endtask

  // One clock: check every output against the model at the falling edge,
  // then advance the model at the rising edge.
  task automatic cycle();
    logic [1:0] efa, efb;
    logic esf, esd, ese, efd, efe, ego;
    bit lw, frozen, abort;
    @(negedge clk);
    lw     = LoadE && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    abort  = m_wait && !mc_done && (m_used + 1 == T);
    frozen = m_wait && !mc_done && !abort;
    efa = fwd_exp(rs1_E); efb = fwd_exp(rs2_E);
    esf = 0; esd = 0; ese = 0; efd = 0; efe = 0; ego = 0;
    if (reset) begin
      efa = 0; efb = 0;
    end else if (!m_wait && mc_start_E) begin
      ego = 1; esf = 1; esd = 1; ese = 1;
    end else if (frozen) begin
      esf = 1; esd = 1; ese = 1;
    end else begin
      esf = lw; esd = lw; efd = PCSrcE; efe = lw | PCSrcE | abort;
    end
    chk("ForwardAE", 8'(ForwardAE), 8'(efa));
    chk("ForwardBE", 8'(ForwardBE), 8'(efb));
    chk("StallF", 8'(StallF), 8'(esf));
    chk("StallD", 8'(StallD), 8'(esd));
    chk("StallE", 8'(StallE), 8'(ese));
    chk("FlushD", 8'(FlushD), 8'(efd));
    chk("FlushE", 8'(FlushE), 8'(efe));
    chk("mc_go", 8'(mc_go), 8'(ego));
    if (!reset) begin
      chk("mc_busy", 8'(mc_busy), 8'(m_wait));
      chk("mc_err", 8'(mc_err), 8'(m_err));
    end
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_used = 0; m_err = 0;
    end else if (!m_wait) begin
      if (mc_start_E) begin m_wait = 1; m_used = 0; end
    end else if (mc_done) begin
      m_wait = 0;
    end else begin
      m_used++;
      if (m_used == T) begin m_wait = 0; m_err = 1; end
    end
    #1;
  endtask

  initial begin
    int n_busy, n_stalle, n_go;
    clear_in();
    reset = 1;
    cycle();
    cycle();
    reset = 0;

    // Forwarding priority and x0 suppression
    rd_M = 5; RegWriteM = 1; rd_W = 5; RegWriteW = 1; rs1_E = 5; rs2_E = 5;
    #1 chk("t1_fwdA_M", 8'(ForwardAE), 8'h2);
    cycle();
    rd_M = 0;
    #1 chk("t1_fwdA_W", 8'(ForwardAE), 8'h1);
    cycle();
    clear_in();

    // Load-use stall
    LoadE = 1; rd_E = 7; rs2_D = 7;
    #1 chk("t2_stallF", 8'(StallF), 8'h1);
    chk("t2_flushE", 8'(FlushE), 8'h1);
    cycle();
    rd_E = 0;
    #1 chk("t2_nostall", 8'(StallF), 8'h0);
    cycle();
    clear_in();

    // Branch flush, then branch coinciding with launch
    PCSrcE = 1;
    #1 chk("t3_flushD", 8'(FlushD), 8'h1);
    chk("t3_stallF", 8'(StallF), 8'h0);
    cycle();
    mc_start_E = 1;
    #1 chk("t3_go_noflush", 8'(FlushD), 8'h0);
    chk("t3_go", 8'(mc_go), 8'h1);
    cycle();
    clear_in();
    mc_done = 1;
    cycle();
    clear_in();

    // Done arrives 4 cycles after mc_go
    n_busy = 0; n_stalle = 0; n_go = 0;
    for (int k = 0; k < 6; k++) begin
      mc_start_E = (k == 0); mc_done = (k == 4);
      #1;
      n_busy += int'(mc_busy); n_stalle += int'(StallE); n_go += int'(mc_go);
      if (k == 4) chk("t4_release", 8'(StallF), 8'h0);
      cycle();
    end
    chk("t4_busy_cycles", 8'(n_busy), 8'd4);
    chk("t4_stallE_cycles", 8'(n_stalle), 8'd4);
    chk("t4_go_count", 8'(n_go), 8'd1);
    clear_in();

    // Timeout abort
    n_busy = 0;
    for (int k = 0; k < 10; k++) begin
      mc_start_E = (k == 0);
      #1;
      n_busy += int'(mc_busy);
      if (k == 8) chk("t5_abort_flushE", 8'(FlushE), 8'h1);
      cycle();
    end
    chk("t5_busy_cycles", 8'(n_busy), 8'd8);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_err_sticky", 8'(mc_err), 8'h1);
      cycle();
    end

    // Reset in the third wait cycle; late done ignored
    for (int k = 0; k < 6; k++) begin
      mc_start_E = (k == 0); reset = (k == 3); mc_done = (k == 4);
      #1;
      if (k == 3) chk("t6_reset_stallE", 8'(StallE), 8'h0);
      if (k == 4) begin
        chk("t6_idle", 8'(mc_busy), 8'h0);
        chk("t6_err_clr", 8'(mc_err), 8'h0);
      end
      cycle();
    end
    clear_in();
    reset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      rs1_D      = RA_W'($urandom_range(0, 3));
      rs2_D      = RA_W'($urandom_range(0, 3));
      rs1_E      = RA_W'($urandom_range(0, 3));
      rs2_E      = RA_W'($urandom_range(0, 3));
      rd_E       = RA_W'($urandom_range(0, 3));
      rd_M       = RA_W'($urandom_range(0, 3));
      rd_W       = RA_W'($urandom_range(0, 3));
      LoadE      = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      mc_start_E = ($urandom_range(0, 7) == 0);
      mc_done    = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
